// File: rtl/ex_result_router.sv
// ex_result_router: routes one EX result to one of 10 consumers through a
// two-entry elastic buffer (head register + skid register). The head entry
// drives the shared out_data and a one-hot out_valid; entries leave in FIFO order.
// Optional feature macro: ROUTER_STATS_EN adds stat_xfer/stat_err counters.
module ex_result_router #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_sel,
    output logic [WIDTH-1:0] out_data,
    output logic [9:0]       out_valid,
    input  logic [9:0]       out_ready,
    output logic             err
`ifdef ROUTER_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_xfer,
    output logic [CNT_W-1:0] stat_err
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic [9:0]       out_valid_q;
    logic [WIDTH-1:0] head_data_q;
    logic [9:0]       skid_dest_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             err_q;

    logic [9:0]       dec_dest;
    logic [WIDTH-1:0] dec_data;
    logic             dec_legal;
    logic             accept;
    logic             acc_legal;
    logic             deliver;

    assign accept    = in_valid & in_ready_q;
    assign acc_legal = accept & dec_legal;
    // Only the bit addressed by the head entry can complete a delivery.
    assign deliver   = |(out_valid_q & out_ready);

    // Decode destination code into a one-hot target and the value to store;
    // dest8/dest9 are 1-bit sinks so only bit 0 of the result is kept.
    always_comb begin
        dec_dest  = 10'd0;
        dec_data  = in_data;
        dec_legal = 1'b1;
        case (in_sel)
            4'd0, 4'd1: dec_dest = 10'b00_0000_0001;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
                dec_dest = 10'b00_0000_0001 << (in_sel - 4'd1);
            4'd9: begin
                dec_dest = 10'b01_0000_0000;
                dec_data = {{(WIDTH-1){1'b0}}, in_data[0]};
            end
            4'd10: begin
                dec_dest = 10'b10_0000_0000;
                dec_data = {{(WIDTH-1){1'b0}}, in_data[0]};
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Buffer FSM with registered handshake outputs; illegal codes complete the
    // handshake but only raise err, leaving the buffer untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 10'd0;
            head_data_q <= '0;
            skid_dest_q <= 10'd0;
            skid_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= accept & ~dec_legal;
            case (state_q)
                EMPTY: begin
                    if (acc_legal) begin
                        out_valid_q <= dec_dest;
                        head_data_q <= dec_data;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (acc_legal && !deliver) begin
                        skid_dest_q <= dec_dest;
                        skid_data_q <= dec_data;
                        in_ready_q  <= 1'b0;
                        state_q     <= TWO;
                    end else if (acc_legal && deliver) begin
                        out_valid_q <= dec_dest;
                        head_data_q <= dec_data;
                    end else if (deliver) begin
                        out_valid_q <= 10'd0;
                        state_q     <= EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        out_valid_q <= skid_dest_q;
                        head_data_q <= skid_data_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 10'd0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_data_q;
    assign err       = err_q;

`ifdef ROUTER_STATS_EN
    logic [CNT_W-1:0] stat_xfer_q;
    logic [CNT_W-1:0] stat_err_q;

    // Free-running wrap-around counters of deliveries and dropped illegal codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_xfer_q <= '0;
            stat_err_q  <= '0;
        end else begin
            if (deliver)
                stat_xfer_q <= stat_xfer_q + 1'b1;
            if (accept && !dec_legal)
                stat_err_q <= stat_err_q + 1'b1;
        end
    end

    assign stat_xfer = stat_xfer_q;
    assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_ex_result_router.sv
// Bench for ex_result_router: reset check, a table of single transfers,
// hand sequences for back-pressure / error pulse / mid-fill reset, then
// randomized traffic against a queue-based reference model.
module tb_ex_result_router;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       in_sel;
    logic [WIDTH-1:0] out_data;
    logic [9:0]       out_valid;
    logic [9:0]       out_ready;
    logic             err;
`ifdef ROUTER_STATS_EN
    logic [CNT_W-1:0] stat_xfer;
    logic [CNT_W-1:0] stat_err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_result_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
`ifdef ROUTER_STATS_EN
        , .stat_xfer(stat_xfer), .stat_err(stat_err)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
        logic [9:0]  exp_valid;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [9:0]  dv;
        logic [31:0] d;
    } ent_t;

    // Reference: code -> destination index by plain arithmetic.
    function automatic ent_t model_map(input logic [3:0] sel, input logic [31:0] d);
        ent_t e;
        int idx;
        idx  = (sel == 0) ? 0 : int'(sel) - 1;
        e.dv = 10'(1) << idx;
        e.d  = (idx >= 8) ? {31'd0, d[0]} : d;
        return e;
    endfunction

    vec_t vecs[10];
    ent_t q[$];

    initial begin
        ent_t e;
        logic exp_err;
        logic deliver, acc, illegal;
        int xfer_cnt, err_cnt;

        vecs[0] = '{4'd3,  32'hDEAD_BEEF, 10'h004, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{4'd0,  32'h1234_5678, 10'h001, 32'h1234_5678, 1'b0};
        vecs[2] = '{4'd1,  32'hCAFE_0001, 10'h001, 32'hCAFE_0001, 1'b0};
        vecs[3] = '{4'd9,  32'hFFFF_FFFE, 10'h100, 32'h0000_0000, 1'b0};
        vecs[4] = '{4'd9,  32'h0000_0003, 10'h100, 32'h0000_0001, 1'b0};
        vecs[5] = '{4'd10, 32'h0000_0005, 10'h200, 32'h0000_0001, 1'b0};
        vecs[6] = '{4'd8,  32'hA5A5_5A5A, 10'h080, 32'hA5A5_5A5A, 1'b0};
        vecs[7] = '{4'd12, 32'h1111_2222, 10'h000, 32'h0,         1'b1};
        vecs[8] = '{4'd2,  32'h0BAD_F00D, 10'h002, 32'h0BAD_F00D, 1'b0};
        vecs[9] = '{4'd15, 32'h3333_4444, 10'h000, 32'h0,         1'b1};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_out_data", out_data, 0);
`ifdef ROUTER_STATS_EN
        chk("rst_stat_xfer", stat_xfer, 0);
        chk("rst_stat_err", stat_err, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);

        // Single transfers from empty with all consumers ready
        out_ready = 10'h3FF;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sel = vecs[i].sel; in_data = vecs[i].data;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            if (vecs[i].exp_valid != 0)
                chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            @(negedge clk);
            chk($sformatf("vec%0d_drained", i), out_valid, 0);
            chk($sformatf("vec%0d_err_clr", i), err, 0);
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
        end

        // Back-pressure: fill both entries, release only dest1
        out_ready = 10'h000;
        in_valid = 1'b1; in_sel = 4'd2; in_data = 32'hAAAA_0001;
        @(negedge clk);
        chk("bp_ready_after_A", in_ready, 1);
        in_sel = 4'd5; in_data = 32'hBBBB_0002;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_ready_after_B", in_ready, 0);
        chk("bp_head_valid", out_valid, 10'h002);
        chk("bp_head_data", out_data, 32'hAAAA_0001);
        @(negedge clk);
        chk("bp_hold_valid", out_valid, 10'h002);
        chk("bp_hold_data", out_data, 32'hAAAA_0001);
        out_ready = 10'h002;
        @(negedge clk);
        chk("bp_B_valid", out_valid, 10'h010);
        chk("bp_B_data", out_data, 32'hBBBB_0002);
        chk("bp_B_in_ready", in_ready, 1);
        @(negedge clk);
        chk("bp_B_held_wrong_ready", out_valid, 10'h010);
        out_ready = 10'h3FF;
        @(negedge clk);
        chk("bp_empty", out_valid, 0);

        // Illegal code while a delivery happens: delivery proceeds, err pulses once
        out_ready = 10'h000;
        in_valid = 1'b1; in_sel = 4'd4; in_data = 32'h4444_4444;
        @(negedge clk);
        out_ready = 10'h3FF; in_sel = 4'd12;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill_err_pulse", err, 1);
        chk("ill_deliver", out_valid, 0);
        @(negedge clk);
        chk("ill_err_once", err, 0);

        // Reset while full discards both entries
        out_ready = 10'h000;
        in_valid = 1'b1; in_sel = 4'd6; in_data = 32'h6666_6666;
        @(negedge clk);
        in_sel = 4'd7; in_data = 32'h7777_7777;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        out_ready = 10'h3FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_delivery", out_valid, 0);
        end

        // Randomized traffic against the queue model
        q.delete();
        exp_err = 1'b0;
        xfer_cnt = 0; err_cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd_valid", out_valid, (q.size() > 0) ? q[0].dv : 10'h000);
            if (q.size() > 0) chk("rnd_data", out_data, q[0].d);
            chk("rnd_in_ready", in_ready, (q.size() < 2));
            chk("rnd_err", err, exp_err);
`ifdef ROUTER_STATS_EN
            chk("rnd_stat_xfer", stat_xfer, CNT_W'(xfer_cnt));
            chk("rnd_stat_err", stat_err, CNT_W'(err_cnt));
`endif
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) == 0) ? 10'h000 : 10'($urandom);
            deliver   = (q.size() > 0) && ((q[0].dv & out_ready) != 0);
            acc       = in_valid && (q.size() < 2);
            illegal   = (in_sel > 4'd10);
            exp_err   = acc && illegal;
            if (deliver) begin
                void'(q.pop_front());
                xfer_cnt++;
            end
            if (acc && !illegal) begin
                e = model_map(in_sel, in_data);
                q.push_back(e);
            end
            if (acc && illegal) err_cnt++;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
